// File: rtl/serial_frame_receiver.sv
// Receive end of the single-wire serial link: synchronises the line, finds each
// start edge, samples bits mid-period and hands complete words over valid/ready.
module serial_frame_receiver #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic [TW-1:0]    r_timer;
    logic [IW-1:0]    r_index;
    logic [WIDTH-1:0] r_shift;

    logic             w_halfDone;
    logic             w_bitDone;
    logic             w_lastBit;
    logic             w_canLoad;
    logic [WIDTH-1:0] w_shiftNext;

    // Two-flop synchroniser; idles high so reset must not look like a start edge.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_halfDone  = (r_timer == TW'(HALF - 1));
        w_bitDone   = (r_timer == TW'(CLKS_PER_BIT - 1));
        w_lastBit   = (r_index == IW'(WIDTH - 1));
        w_canLoad   = !out_valid || out_ready;
        w_shiftNext = '0;
        if (MSB_FIRST)
            w_shiftNext = (r_shift << 1) | WIDTH'(r_sync2);
        else
            w_shiftNext = (r_shift >> 1) | (WIDTH'(r_sync2) << (WIDTH - 1));
    end

    // A load on the stop-sample edge overrides the consume-clear of out_valid.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_index   <= '0;
            r_shift   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!r_sync2) begin
                        r_state <= START;
                        r_timer <= '0;
                    end
                end
                START: begin
                    if (w_halfDone) begin
                        r_timer <= '0;
                        r_index <= '0;
                        r_state <= r_sync2 ? IDLE : DATA;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                DATA: begin
                    if (w_bitDone) begin
                        r_timer <= '0;
                        r_shift <= w_shiftNext;
                        if (w_lastBit)
                            r_state <= STOP;
                        else
                            r_index <= r_index + IW'(1);
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                STOP: begin
                    if (w_bitDone) begin
                        r_timer <= '0;
                        if (r_sync2) begin
                            r_state <= IDLE;
                            if (w_canLoad) begin
                                out_data  <= r_shift;
                                out_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= WAIT_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (r_sync2)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: one MSB-first and one LSB-first
// instance share the line, with hand-computed words and edge numbers.
module tb_serial_frame_receiver;

    localparam int CPB = 4;

    logic       clk;
    logic       clear;
    logic       lineIn;
    logic       outReady;
    logic [3:0] dataM;
    logic [3:0] dataL;
    logic       validM;
    logic       validL;
    logic       errM;
    logic       errL;
    logic       ovrM;
    logic       ovrL;

    int checksTotal  = 0;
    int checksPassed = 0;
    int cycle        = 0;
    int rises        = 0;
    int validCycles  = 0;
    int errCycles    = 0;
    int ovrCycles    = 0;
    int lastRise     = -1;
    int lastErr      = -1;
    int lastOvr      = -1;
    logic prevValid  = 1'b0;

    serial_frame_receiver #(.WIDTH(4), .CLKS_PER_BIT(CPB), .MSB_FIRST(1'b1)) dutM (
        .clk(clk), .clear(clear), .in(lineIn),
        .out_data(dataM), .out_valid(validM), .out_ready(outReady),
        .frame_err(errM), .overrun(ovrM)
    );

    serial_frame_receiver #(.WIDTH(4), .CLKS_PER_BIT(CPB), .MSB_FIRST(1'b0)) dutL (
        .clk(clk), .clear(clear), .in(lineIn),
        .out_data(dataL), .out_valid(validL), .out_ready(outReady),
        .frame_err(errL), .overrun(ovrL)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    // Event recorder for the MSB-first instance, sampled on the falling edge.
    always @(negedge clk) begin
        if (validM && !prevValid) begin
            rises    <= rises + 1;
            lastRise <= cycle;
        end
        prevValid <= validM;
        if (validM) validCycles <= validCycles + 1;
        if (errM) begin
            errCycles <= errCycles + 1;
            lastErr   <= cycle;
        end
        if (ovrM) begin
            ovrCycles <= ovrCycles + 1;
            lastOvr   <= cycle;
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checksTotal++;
        if (observed == expected)
            checksPassed++;
        else
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start, four data bits (bits[3] first on the line) and a stop bit.
    task automatic applyStimulus(input logic [3:0] bits, input logic stopBit, output int e0);
        e0 = cycle;
        lineIn = 1'b0;
        repeat (CPB) tick();
        for (int i = 3; i >= 0; i--) begin
            lineIn = bits[i];
            repeat (CPB) tick();
        end
        lineIn = stopBit;
        repeat (CPB) tick();
    endtask

    int e0;
    int e0b;
    int bRise;
    int bValid;
    int bErr;
    int bOvr;

    initial begin
        clear    = 1'b1;
        lineIn   = 1'b1;
        outReady = 1'b1;
        #15;
        checkOutput("reset_data", int'(dataM), 0);
        checkOutput("reset_valid", int'(validM), 0);
        checkOutput("reset_err", int'(errM), 0);
        checkOutput("reset_ovr", int'(ovrM), 0);
        #5 clear = 1'b0;
        tick();
        repeat (3) tick();

        // Test 1: basic frame, out_ready held high
        bRise = rises; bValid = validCycles; bErr = errCycles; bOvr = ovrCycles;
        applyStimulus(4'b1010, 1'b1, e0);
        repeat (6) tick();
        checkOutput("t1_rise_edge", lastRise, e0 + 25);
        checkOutput("t1_valid_cycles", validCycles - bValid, 1);
        checkOutput("t1_data_msb", int'(dataM), 4'b1010);
        checkOutput("t1_data_lsb", int'(dataL), 4'b0101);
        checkOutput("t1_err", errCycles - bErr, 0);
        checkOutput("t1_ovr", ovrCycles - bOvr, 0);

        // Test 2: one-clock glitch must be rejected, then a real frame still works
        bRise = rises; bErr = errCycles;
        lineIn = 1'b0;
        tick();
        lineIn = 1'b1;
        repeat (12) tick();
        checkOutput("t2_glitch_valid", rises - bRise, 0);
        checkOutput("t2_glitch_err", errCycles - bErr, 0);
        applyStimulus(4'b1010, 1'b1, e0);
        repeat (4) tick();
        checkOutput("t2_after_glitch_rise", lastRise, e0 + 25);
        checkOutput("t2_after_glitch_lsb", int'(dataL), 4'b0101);

        // Test 3: bad stop bit then line held low
        bRise = rises; bErr = errCycles;
        applyStimulus(4'b1100, 1'b0, e0);
        repeat (3 * CPB) tick();
        checkOutput("t3_err_cycles", errCycles - bErr, 1);
        checkOutput("t3_err_edge", lastErr, e0 + 25);
        checkOutput("t3_no_valid_low", rises - bRise, 0);
        lineIn = 1'b1;
        repeat (6) tick();
        checkOutput("t3_no_valid_high", rises - bRise, 0);
        checkOutput("t3_err_after", errCycles - bErr, 1);

        // Test 4: consumer stalled, second word overruns
        outReady = 1'b0;
        bOvr = ovrCycles;
        applyStimulus(4'b1010, 1'b1, e0);
        applyStimulus(4'b0011, 1'b1, e0b);
        repeat (4) tick();
        checkOutput("t4_first_rise", lastRise, e0 + 25);
        checkOutput("t4_ovr_cycles", ovrCycles - bOvr, 1);
        checkOutput("t4_ovr_edge", lastOvr, e0b + 25);
        checkOutput("t4_data_held", int'(dataM), 4'b1010);
        checkOutput("t4_valid_held", int'(validM), 1);
        outReady = 1'b1;
        tick();
        checkOutput("t4_valid_dropped", int'(validM), 0);
        checkOutput("t4_data_kept", int'(dataM), 4'b1010);
        outReady = 1'b0;

        // Test 5: consume on the same edge as the second load
        bOvr = ovrCycles;
        fork
            begin
                applyStimulus(4'b1010, 1'b1, e0);
                applyStimulus(4'b0011, 1'b1, e0b);
            end
            begin
                repeat (48) tick();
                outReady = 1'b1;
                tick();
                outReady = 1'b0;
            end
        join
        checkOutput("t5_data_msb", int'(dataM), 4'b0011);
        checkOutput("t5_data_lsb", int'(dataL), 4'b1100);
        checkOutput("t5_valid", int'(validM), 1);
        checkOutput("t5_ovr", ovrCycles - bOvr, 0);

        // Test 6: asynchronous clear mid-frame, then recovery
        lineIn = 1'b0;
        repeat (10) tick();
        #3 clear = 1'b1;
        #1;
        checkOutput("t6_clear_data", int'(dataM), 0);
        checkOutput("t6_clear_data_lsb", int'(dataL), 0);
        checkOutput("t6_clear_valid", int'(validM), 0);
        lineIn = 1'b1;
        tick();
        clear = 1'b0;
        repeat (4) tick();
        outReady = 1'b1;
        applyStimulus(4'b0110, 1'b1, e0);
        repeat (4) tick();
        checkOutput("t6_rise_edge", lastRise, e0 + 25);
        checkOutput("t6_data", int'(dataM), 4'b0110);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
